// File: rtl/hls2x8_5_div_pkg.sv
// Shared state encoding and constants for the sequential signed divider.
package hls2x8_5_div_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam int unsigned W_DEFAULT = 16;

   localparam logic [W_DEFAULT-1:0] ALL_ONES = {W_DEFAULT{1'b1}};
   localparam logic [W_DEFAULT-1:0] MIN_NEG  = {1'b1, {(W_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/hls2x8_5_sdiv_step.sv
// One unsigned restoring division step: trial-subtract the divisor from the
// already-shifted partial remainder and keep the difference when it fits.
module hls2x8_5_sdiv_step #(
   parameter int unsigned W = 16
) (
   input  logic [W:0]   rem_in,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_out,
   output logic         q_bit
);

   logic [W-1:0] diff;

   // When the subtraction succeeds the difference is below the divisor, so W bits suffice.
   assign q_bit   = (rem_in >= {1'b0, divisor});
   assign diff    = rem_in[W-1:0] - divisor;
   assign rem_out = q_bit ? diff : rem_in[W-1:0];

endmodule

// File: rtl/hls2x8_5_sdiv_seq_cud.sv
// Sequential signed divider with C truncation semantics, one quotient bit per cycle.
// HLS2X8_5_SDIV_EARLY_DIV0_EN: a zero divisor skips the iteration and finishes one cycle after acceptance.
module hls2x8_5_sdiv_seq_cud
   import hls2x8_5_div_pkg::*;
#(
   parameter int unsigned ID         = 32'd1,
   parameter int unsigned din0_WIDTH = W_DEFAULT,
   parameter int unsigned din1_WIDTH = W_DEFAULT,
   parameter int unsigned dout_WIDTH = W_DEFAULT
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  ready,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout,
   output logic [dout_WIDTH-1:0] remd,
   output logic                  div0
);

   localparam int unsigned   W    = din0_WIDTH;
   localparam int unsigned   CW   = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   if (din1_WIDTH != W || dout_WIDTH != W || W < 2 || $bits(ID) != 32) begin : g_bad_cfg
      $error("hls2x8_5_sdiv_seq_cud: all operand widths must match and be at least 2");
   end

   state_t        state_q, state_d, accept_state;
   logic          accept;
   logic [W-1:0]  mag0, mag1;
   logic [W-1:0]  rem_q, quo_q, dvs_q;
   logic [CW-1:0] cnt_q;
   logic          neg_q, dsign_q, zero_q;
   logic [W-1:0]  step_rem, q_fix, r_fix;
   logic          step_q;

   assign ready  = (state_q == IDLE) || (state_q == DONE);
   assign done   = (state_q == DONE);
   assign accept = start && ready;

   assign mag0  = din0[W-1] ? -din0 : din0;
   assign mag1  = din1[W-1] ? -din1 : din1;
   assign q_fix = neg_q   ? -quo_q : quo_q;
   assign r_fix = dsign_q ? -rem_q : rem_q;

   hls2x8_5_sdiv_step #(.W(W)) u_step (
      .rem_in  ({rem_q, quo_q[W-1]}),
      .divisor (dvs_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_comb begin
      accept_state = CALC;
`ifdef HLS2X8_5_SDIV_EARLY_DIV0_EN
      if (din1 == '0) accept_state = DONE;
`endif
   end

   // NOTE: every variable written here gets its default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = accept_state;
         CALC:    if (cnt_q == LAST) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    state_d = start ? accept_state : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= IDLE;
         dout    <= '0;
         remd    <= '0;
         div0    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == FIX) begin
            dout <= zero_q ? '1 : q_fix;
            remd <= r_fix;
            div0 <= zero_q;
         end else if (accept && accept_state == DONE) begin
            dout <= '1;
            remd <= din0;
            div0 <= 1'b1;
         end
      end
   end

   // NOTE: the iteration datapath needs no reset; it is always reloaded on acceptance before use.
   always_ff @(posedge ap_clk) begin
      if (accept) begin
         rem_q   <= '0;
         quo_q   <= mag0;
         dvs_q   <= mag1;
         neg_q   <= din0[W-1] ^ din1[W-1];
         dsign_q <= din0[W-1];
         zero_q  <= (din1 == '0);
         cnt_q   <= '0;
      end else if (state_q == CALC) begin
         rem_q <= step_rem;
         quo_q <= {quo_q[W-2:0], step_q};
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule
